// File: rtl/pipe_pkg.sv
// Shared EXE/MEM pipeline definitions: default field widths, control bundle and payload sizing.
package pipe_pkg;

    localparam int unsigned PC_W_DEF    = 32;
    localparam int unsigned INSTR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned REG_W_DEF   = 4;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic wb_en;
    } ctrl_t;

    localparam int unsigned CTRL_W = $bits(ctrl_t);

    // Packed payload layout, MSB first: pc, instruction, dst, alu_res, val_rm, ctrl.
    function automatic int unsigned payload_w(input int unsigned pc_w, input int unsigned instr_w,
                                              input int unsigned reg_w, input int unsigned data_w);
        return pc_w + instr_w + reg_w + 2 * data_w + CTRL_W;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Single skid entry: catches one payload while the downstream register is stalled.
module pipe_skid_buf #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic         valid,
    output logic         ready,
    output logic [W-1:0] data
);

    // ready is kept as its own flop so the upstream sees a register, not logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            ready <= 1'b1;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            ready <= 1'b1;
        end else if (push) begin
            valid <= 1'b1;
            ready <= 1'b0;
            data  <= push_data;
        end else if (pop) begin
            valid <= 1'b0;
            ready <= 1'b1;
        end
    end

endmodule

// File: rtl/exe_mem_pipe_stage.sv
// EXE->MEM pipeline register with valid/ready handshake, flush and optional skid entry.
module exe_mem_pipe_stage
    import pipe_pkg::*;
#(
    parameter int unsigned PC_W    = PC_W_DEF,
    parameter int unsigned INSTR_W = INSTR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned REG_W   = REG_W_DEF,
    parameter int unsigned SKID_EN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    pc_in,
    input  logic [INSTR_W-1:0] instruction_in,
    input  logic [REG_W-1:0]   dst_in,
    input  logic [DATA_W-1:0]  ALU_res_in,
    input  logic [DATA_W-1:0]  val_Rm_in,
    input  logic               mem_read_in,
    input  logic               mem_write_in,
    input  logic               WB_en_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] instruction,
    output logic [REG_W-1:0]   dst_out,
    output logic [DATA_W-1:0]  ALU_res_out,
    output logic [DATA_W-1:0]  val_Rm_out,
    output logic               mem_read_out,
    output logic               mem_write_out,
    output logic               WB_en_out
);

    localparam int unsigned PW     = payload_w(PC_W, INSTR_W, REG_W, DATA_W);
    localparam int unsigned DATA_PW = PW - CTRL_W;

    ctrl_t                ctrl_in;
    ctrl_t                ctrl_q;
    logic [PW-1:0]        in_payload;
    logic [PW-1:0]        src_payload;
    logic [PW-1:0]        skid_data;
    logic [DATA_PW-1:0]   main_data;
    logic                 skid_valid;
    logic                 accept;
    logic                 load;
    logic                 src_valid;

    assign ctrl_in    = '{mem_read: mem_read_in, mem_write: mem_write_in, wb_en: WB_en_in};
    assign in_payload = {pc_in, instruction_in, dst_in, ALU_res_in, val_Rm_in, ctrl_in};

    assign accept      = in_valid & in_ready;
    assign load        = !out_valid | out_ready;
    // The skid entry is older than anything on the input, so it always wins the main register.
    assign src_valid   = skid_valid | accept;
    assign src_payload = skid_valid ? skid_data : in_payload;

    generate
        if (SKID_EN != 0) begin : g_skid
            logic skid_ready;

            pipe_skid_buf #(
                .W (PW)
            ) u_skid (
                .clk       (clk),
                .rst_n     (rst_n),
                .flush     (flush),
                .push      (accept & !load),
                .pop       (load),
                .push_data (in_payload),
                .valid     (skid_valid),
                .ready     (skid_ready),
                .data      (skid_data)
            );

            assign in_ready = skid_ready;
        end else begin : g_no_skid
            assign skid_valid = 1'b0;
            assign skid_data  = '0;
            assign in_ready   = load;
        end
    endgenerate

    // Main register: controls are zeroed on bubbles, data fields keep their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            main_data <= '0;
            ctrl_q    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            ctrl_q    <= '0;
        end else if (load) begin
            out_valid <= src_valid;
            if (src_valid) begin
                main_data <= src_payload[PW-1:CTRL_W];
                ctrl_q    <= ctrl_t'(src_payload[CTRL_W-1:0]);
            end else begin
                ctrl_q    <= '0;
            end
        end
    end

    assign {pc, instruction, dst_out, ALU_res_out, val_Rm_out} = main_data;
    assign mem_read_out  = ctrl_q.mem_read;
    assign mem_write_out = ctrl_q.mem_write;
    assign WB_en_out     = ctrl_q.wb_en;

endmodule
